// File: rtl/fpu_wb_ctl.sv
// FPU writeback controller: tracks one in-flight FP op, waits for the single- or
// multi-cycle unit, then issues a one-cycle register-file writeback and accrues flags.
module fpu_wb_ctl #(
  parameter int FPLEN   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_mc,
  input  logic             issue_fd_wr,
  input  logic             issue_xd_wr,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic             sc_valid,
  input  logic [FPLEN-1:0] sc_result,
  input  logic [4:0]       sc_flags,
  input  logic             mc_valid,
  input  logic [FPLEN-1:0] mc_result,
  input  logic [4:0]       mc_flags,
  input  logic             fflags_clr,
  output logic             fpu_complete,
  output logic [FPLEN-1:0] fpu_result_1,
  output logic             fp_wen,
  output logic             int_wen,
  output logic [4:0]       wb_rd,
  output logic [4:0]       fflags,
  output logic             halt,
  output logic             timeout_err,
  output logic [1:0]       dbg_state
);

  // Handshake: issue_valid is a one-cycle pulse, accepted only in the cycle
  // issue_ready is high; unit valids are single-cycle strobes honoured only
  // while waiting on that unit. There is no backpressure on the writeback side.

  typedef enum logic [1:0] {IDLE, WAIT_SC, WAIT_MC, WB} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             cap_fd;
  logic             cap_xd;
  logic [4:0]       cap_rd;

  logic             wb_go;
  logic             wb_ok;
  logic             to_hit;
  logic [FPLEN-1:0] wb_data;
  logic [4:0]       wb_flags;

  assign dbg_state = state;

  // Decide whether this cycle ends the wait, and with what payload.
  always_comb begin
    wb_go    = 1'b0;
    wb_ok    = 1'b0;
    to_hit   = 1'b0;
    wb_data  = '0;
    wb_flags = '0;
    if (state == WAIT_SC && sc_valid) begin
      wb_go    = 1'b1;
      wb_ok    = 1'b1;
      wb_data  = sc_result;
      wb_flags = sc_flags;
    end else if (state == WAIT_MC && mc_valid) begin
      wb_go    = 1'b1;
      wb_ok    = 1'b1;
      wb_data  = mc_result;
      wb_flags = mc_flags;
    end else if ((state == WAIT_SC || state == WAIT_MC) && wait_cnt == TO_LAST) begin
      wb_go  = 1'b1;
      to_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      cap_fd       <= 1'b0;
      cap_xd       <= 1'b0;
      cap_rd       <= '0;
      issue_ready  <= 1'b1;
      fpu_complete <= 1'b0;
      fpu_result_1 <= '0;
      fp_wen       <= 1'b0;
      int_wen      <= 1'b0;
      wb_rd        <= '0;
      fflags       <= '0;
      halt         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      fpu_complete <= 1'b0;
      fp_wen       <= 1'b0;
      int_wen      <= 1'b0;

      // A clear in the accumulation cycle keeps only the new flags.
      if (wb_go) fflags <= (fflags_clr ? 5'd0 : fflags) | wb_flags;
      else if (fflags_clr) fflags <= '0;

      case (state)
        IDLE: begin
          if (issue_valid) begin
            cap_fd      <= issue_fd_wr;
            cap_xd      <= issue_xd_wr & ~issue_fd_wr;
            cap_rd      <= issue_rd;
            wait_cnt    <= '0;
            issue_ready <= 1'b0;
            halt        <= issue_mc;
            state       <= issue_mc ? WAIT_MC : WAIT_SC;
          end
        end
        WAIT_SC, WAIT_MC: begin
          if (wb_go) begin
            state        <= WB;
            fpu_complete <= 1'b1;
            fpu_result_1 <= wb_data;
            wb_rd        <= cap_rd;
            fp_wen       <= wb_ok & cap_fd;
            int_wen      <= wb_ok & cap_xd;
            if (to_hit) timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state       <= IDLE;
          issue_ready <= 1'b1;
          halt        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_wb_ctl.sv
// Bench for fpu_wb_ctl: directed scenarios plus randomized ops checked cycle by
// cycle against an op-level timing/flag model.
module tb_fpu_wb_ctl;

  localparam int FPLEN   = 32;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_mc, issue_fd_wr, issue_xd_wr;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic             sc_valid, mc_valid;
  logic [FPLEN-1:0] sc_result, mc_result;
  logic [4:0]       sc_flags, mc_flags;
  logic             fflags_clr;
  logic             fpu_complete;
  logic [FPLEN-1:0] fpu_result_1;
  logic             fp_wen, int_wen;
  logic [4:0]       wb_rd;
  logic [4:0]       fflags;
  logic             halt, timeout_err;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [4:0]       exp_ff;
  logic             exp_terr;
  logic [FPLEN-1:0] exp_q[$];

  fpu_wb_ctl #(.FPLEN(FPLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_mc(issue_mc), .issue_fd_wr(issue_fd_wr),
    .issue_xd_wr(issue_xd_wr), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .sc_valid(sc_valid), .sc_result(sc_result), .sc_flags(sc_flags),
    .mc_valid(mc_valid), .mc_result(mc_result), .mc_flags(mc_flags),
    .fflags_clr(fflags_clr), .fpu_complete(fpu_complete), .fpu_result_1(fpu_result_1),
    .fp_wen(fp_wen), .int_wen(int_wen), .wb_rd(wb_rd), .fflags(fflags),
    .halt(halt), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_mc = 1'b0; issue_fd_wr = 1'b0; issue_xd_wr = 1'b0;
    issue_rd = '0; sc_valid = 1'b0; mc_valid = 1'b0; sc_result = '0; mc_result = '0;
    sc_flags = '0; mc_flags = '0; fflags_clr = 1'b0;
  endtask

  // One op: issue at cycle 0, response at cycle lat (none if lat > TIMEOUT).
  // clr_mode: 0 never, 1 in the accumulation cycle, 2 random.
  task automatic run_op(input bit mc, input bit fd, input bit xd, input logic [4:0] rd,
                        input int lat, input logic [31:0] res, input logic [4:0] flg,
                        input int clr_mode, input bit noise);
    bit to;
    int wb;
    int n;
    bit hit;
    logic [31:0] exp_res;
    to = (lat > TIMEOUT);
    wb = to ? TIMEOUT + 1 : lat + 1;
    for (int c = 0; c <= wb; c++) begin
      hit = (c == lat) && !to;
      issue_valid = (c == 0) || (noise && c == 1);
      if (c == 0) begin
        issue_mc = mc; issue_fd_wr = fd; issue_xd_wr = xd; issue_rd = rd;
      end else begin
        issue_mc = 1'($urandom_range(0, 1)); issue_fd_wr = 1'($urandom_range(0, 1));
        issue_xd_wr = 1'($urandom_range(0, 1)); issue_rd = 5'($urandom_range(0, 31));
      end
      sc_result = $urandom; mc_result = $urandom;
      sc_flags = 5'($urandom_range(0, 31)); mc_flags = 5'($urandom_range(0, 31));
      if (mc) begin
        mc_valid = hit || (noise && (c == 0 || c == wb) && $urandom_range(0, 1) == 1);
        sc_valid = noise && $urandom_range(0, 1) == 1;
        if (hit) begin mc_result = res; mc_flags = flg; end
      end else begin
        sc_valid = hit || (noise && (c == 0 || c == wb) && $urandom_range(0, 1) == 1);
        mc_valid = noise && $urandom_range(0, 1) == 1;
        if (hit) begin sc_result = res; sc_flags = flg; end
      end
      fflags_clr = (clr_mode == 1) ? (c == wb - 1) :
                   (clr_mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (c == wb - 1) begin
        exp_ff = (fflags_clr ? 5'd0 : exp_ff) | (to ? 5'd0 : flg);
        exp_q.push_back(to ? 32'd0 : res);
        if (to) exp_terr = 1'b1;
      end else if (fflags_clr) begin
        exp_ff = '0;
      end
      step();
      n = c + 1;
      check("complete", 32'(fpu_complete), 32'(n == wb));
      check("halt", 32'(halt), 32'(mc && n <= wb));
      check("issue_ready", 32'(issue_ready), 32'(n > wb));
      check("fflags", 32'(fflags), 32'(exp_ff));
      check("timeout_err", 32'(timeout_err), 32'(exp_terr));
      if (n == wb) begin
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("result", fpu_result_1, exp_res);
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("fp_wen", 32'(fp_wen), 32'(!to && fd));
        check("int_wen", 32'(int_wen), 32'(!to && xd && !fd));
      end else begin
        check("wen_quiet", 32'({fp_wen, int_wen}), 32'd0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    int lat;
    idle_inputs();
    exp_ff = '0;
    exp_terr = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_complete", 32'(fpu_complete), 32'd0);
    check("rst_result", fpu_result_1, 32'd0);
    check("rst_wen", 32'({fp_wen, int_wen}), 32'd0);
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();

    // directed scenarios
    run_op(1'b0, 1'b1, 1'b0, 5'd5, 1, 32'h3F80_0000, 5'h01, 0, 1'b0);
    check("fflags_sc", 32'(fflags), 32'h01);
    run_op(1'b1, 1'b0, 1'b0, 5'd9, 20, 32'h4049_0FDB, 5'h08, 0, 1'b0);
    check("fflags_acc", 32'(fflags), 32'h09);
    run_op(1'b0, 1'b0, 1'b1, 5'd3, 1, 32'h0000_0001, 5'h00, 0, 1'b1);
    run_op(1'b0, 1'b1, 1'b1, 5'd17, 3, 32'hC000_0000, 5'h02, 0, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 5'd4, 2, 32'h0000_0000, 5'h04, 0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 5'd12, TIMEOUT, 32'h1234_5678, 5'h00, 0, 1'b0);
    check("no_terr_at_edge", 32'(timeout_err), 32'd0);
    run_op(1'b1, 1'b1, 1'b0, 5'd7, TIMEOUT + 10, 32'h0, 5'h00, 0, 1'b1);
    check("terr_set", 32'(timeout_err), 32'd1);
    run_op(1'b0, 1'b1, 1'b0, 5'd1, 2, 32'h3F00_0000, 5'h10, 1, 1'b0);
    check("fflags_clr_wb", 32'(fflags), 32'h10);

    // async reset in WAIT_MC, then stray strobes in IDLE
    issue_valid = 1'b1; issue_mc = 1'b1; issue_fd_wr = 1'b1; issue_rd = 5'd20;
    step();
    idle_inputs();
    step();
    step();
    check("pre_rst_halt", 32'(halt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_halt", 32'(halt), 32'd0);
    check("arst_fflags", 32'(fflags), 32'd0);
    check("arst_ready", 32'(issue_ready), 32'd1);
    check("arst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    exp_ff = '0;
    exp_terr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      mc_valid = 1'b1; sc_valid = 1'b1; mc_flags = 5'h1F; sc_flags = 5'h1F;
      step();
      check("stray_complete", 32'(fpu_complete), 32'd0);
      check("stray_ready", 32'(issue_ready), 32'd1);
      check("stray_fflags", 32'(fflags), 32'd0);
    end
    idle_inputs();

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       lat = TIMEOUT + 1 + int'($urandom_range(0, 5));
        1:       lat = TIMEOUT;
        default: lat = int'($urandom_range(1, 25));
      endcase
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), lat, $urandom, 5'($urandom_range(0, 31)),
             2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
